load_store_unit: RTL and testbench

Parametrised load/store unit for the core's MEM stage, successor to the combinational memory address path. Computes the effective address (base + offset), generates byte enables and lane-aligned store data, and runs a request/grant/response handshake to data memory through a small state machine. It returns sign- or zero-extended load data to writeback and stalls the pipeline while an access is outstanding. It also detects misaligned accesses and memory timeouts.

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: effective address, lane formatting, req/gnt/rvalid handshake, timeout.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned ops instead of force-aligning them.
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [XLEN-1:0]   base_i,
    input  logic [XLEN-1:0]   offset_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [4:0]        rd_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic [4:0]        rd_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              fault_o,
    output logic [XLEN-1:0]   fault_addr_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN/8-1:0] dmem_be_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_next;

    logic [XLEN-1:0] ea_raw, ea_eff, amask, wdata_rep;
    logic [NB-1:0]   be_base, be;
    logic            illegal, trap, accept, go_req, trap_event;
    logic            expired, resp_event, fault_event;
    logic [XLEN-1:0] ea_q;
    logic            we_q, unsigned_q;
    logic [1:0]      size_q;
    logic [4:0]      rd_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] shifted, ext_mask, load_data;
    logic            sign;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            misaligned;
`endif

    always_comb begin
        ea_raw = base_i + offset_i;
        case (size_i)
            2'd0:    amask = '0;
            2'd1:    amask = XLEN'(1);
            2'd2:    amask = XLEN'(3);
            default: amask = XLEN'(7);
        endcase
        illegal = (XLEN == 32) && (size_i == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = |(ea_raw & amask);
        trap       = illegal || misaligned;
        ea_eff     = ea_raw;
`else
        trap       = illegal;
        ea_eff     = ea_raw & ~amask;
`endif
        case (size_i)
            2'd0:    be_base = NB'(1);
            2'd1:    be_base = NB'(3);
            2'd2:    be_base = NB'(4'hF);
            default: be_base = '1;
        endcase
        be = be_base << ea_eff[LB-1:0];
        case (size_i)
            2'd0:    wdata_rep = {NB{wdata_i[7:0]}};
            2'd1:    wdata_rep = {(NB/2){wdata_i[15:0]}};
            2'd2:    wdata_rep = {(NB/4){wdata_i[31:0]}};
            default: wdata_rep = wdata_i;
        endcase
        accept     = req_valid_i && (state == IDLE);
        go_req     = accept && !trap;
        trap_event = accept && trap;
    end

    // Fault becomes visible TIMEOUT_CYCLES cycles after accept (counter is 0 in the first REQ cycle).
    assign expired = (cnt >= CW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        resp_event  = 1'b0;
        fault_event = 1'b0;
        case (state)
            IDLE: if (go_req) state_next = REQ;
            REQ: begin
                if (expired) begin
                    state_next  = IDLE;
                    fault_event = 1'b1;
                end else if (dmem_gnt_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_next = IDLE;
                    resp_event = 1'b1;
                end else if (expired) begin
                    state_next  = IDLE;
                    fault_event = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state == IDLE);
        stall_o     = (state == REQ) || (state == WAIT);
    end

    always_comb begin
        shifted = dmem_rdata_i >> {ea_q[LB-1:0], 3'b000};
        case (size_q)
            2'd0:    begin ext_mask = XLEN'(8'hFF);         sign = shifted[7];      end
            2'd1:    begin ext_mask = XLEN'(16'hFFFF);      sign = shifted[15];     end
            2'd2:    begin ext_mask = XLEN'(32'hFFFF_FFFF); sign = shifted[31];     end
            default: begin ext_mask = '1;                   sign = shifted[XLEN-1]; end
        endcase
        load_data = (shifted & ext_mask) | ((sign && !unsigned_q) ? ~ext_mask : '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_o <= 1'b0;
            rdata_o      <= '0;
            rd_o         <= '0;
            misalign_o   <= 1'b0;
            fault_o      <= 1'b0;
            fault_addr_o <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            ea_q         <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            rd_q         <= '0;
            cnt          <= '0;
        end else begin
            resp_valid_o <= resp_event;
            rdata_o      <= (resp_event && !we_q) ? load_data : '0;
            rd_o         <= resp_event ? rd_q : '0;
            misalign_o   <= trap_event;
            fault_o      <= fault_event;
            if (trap_event)       fault_addr_o <= ea_raw;
            else if (fault_event) fault_addr_o <= ea_q;
            else                  fault_addr_o <= '0;
            dmem_req_o <= (state_next == REQ);
            if (go_req) begin
                ea_q         <= ea_eff;
                we_q         <= we_i;
                size_q       <= size_i;
                unsigned_q   <= unsigned_i;
                rd_q         <= rd_i;
                dmem_we_o    <= we_i;
                dmem_addr_o  <= {ea_eff[XLEN-1:LB], {LB{1'b0}}};
                dmem_be_o    <= be;
                dmem_wdata_o <= wdata_rep;
            end
            if (accept)              cnt <= '0;
            else if (state != IDLE)  cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (XLEN=32, TIMEOUT_CYCLES=16).
module tb_load_store_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_ready, we, uns;
    logic [1:0]      size;
    logic [XLEN-1:0] base, offset, wdata;
    logic [4:0]      rd, rd_out;
    logic            resp_valid, stall, misalign, fault;
    logic [XLEN-1:0] rdata, fault_addr;
    logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]      dmem_be;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .we_i(we), .size_i(size), .unsigned_i(uns),
        .base_i(base), .offset_i(offset), .wdata_i(wdata), .rd_i(rd),
        .resp_valid_o(resp_valid), .rdata_o(rdata), .rd_o(rd_out),
        .stall_o(stall), .misalign_o(misalign), .fault_o(fault), .fault_addr_o(fault_addr),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] b, input logic [31:0] o,
                         input logic [31:0] wd, input logic [4:0] r);
        req_valid = 1'b1; we = w; size = sz; uns = u;
        base = b; offset = o; wdata = wd; rd = r;
    endtask

    // Full-speed access: grant in cycle 1, response in cycle 2, result in cycle 3.
    task automatic op(input string nm, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] b, input logic [31:0] o, input logic [31:0] wd,
                      input logic [4:0] r, input logic [31:0] mem,
                      input logic [31:0] e_addr, input logic [3:0] e_be,
                      input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        check({nm, ".ready"}, 32'(req_ready), 32'd1);
        issue(w, sz, u, b, o, wd, r);
        step();
        req_valid = 1'b0;
        check({nm, ".req"},   32'(dmem_req), 32'd1);
        check({nm, ".addr"},  dmem_addr, e_addr);
        check({nm, ".be"},    32'(dmem_be), 32'(e_be));
        check({nm, ".we"},    32'(dmem_we), 32'(w));
        if (w) check({nm, ".wdata"}, dmem_wdata, e_wdata);
        check({nm, ".stall1"}, 32'(stall), 32'd1);
        check({nm, ".mis"},    32'(misalign), 32'd0);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check({nm, ".stall2"}, 32'(stall), 32'd1);
        check({nm, ".reqdrop"}, 32'(dmem_req), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = mem;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        check({nm, ".resp"},  32'(resp_valid), 32'd1);
        check({nm, ".rdata"}, rdata, e_rdata);
        check({nm, ".rd"},    32'(rd_out), 32'(r));
        check({nm, ".stall3"}, 32'(stall), 32'd0);
        check({nm, ".ready3"}, 32'(req_ready), 32'd1);
        step();
        check({nm, ".resp0"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; we = 1'b0; uns = 1'b0; size = '0;
        base = '0; offset = '0; wdata = '0; rd = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) step();
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.req",   32'(dmem_req), 32'd0);
        check("rst.resp",  32'(resp_valid), 32'd0);
        check("rst.fault", 32'(fault), 32'd0);
        check("rst.mis",   32'(misalign), 32'd0);
        rst = 1'b0;
        step();

        op("lw",    0, 2'd2, 0, 32'h1000, 32'h4, 32'h0, 5'd5, 32'hDEADBEEF, 32'h1004, 4'hF, 32'h0, 32'hDEADBEEF);
        op("lb",    0, 2'd0, 0, 32'h2000, 32'h3, 32'h0, 5'd6, 32'h80112233, 32'h2000, 4'h8, 32'h0, 32'hFFFFFF80);
        op("lbu",   0, 2'd0, 1, 32'h2000, 32'h3, 32'h0, 5'd7, 32'h80112233, 32'h2000, 4'h8, 32'h0, 32'h00000080);
        op("sh",    1, 2'd1, 0, 32'h2000, 32'h2, 32'h0000ABCD, 5'd8, 32'h12345678, 32'h2000, 4'hC, 32'hABCDABCD, 32'h0);
        op("lh",    0, 2'd1, 0, 32'h2000, 32'h2, 32'h0, 5'd9, 32'h80112233, 32'h2000, 4'hC, 32'h0, 32'hFFFF8011);
        op("lhu",   0, 2'd1, 1, 32'h2000, 32'h0, 32'h0, 5'd10, 32'h80118234, 32'h2000, 4'h3, 32'h0, 32'h00008234);
        op("lbpos", 0, 2'd0, 0, 32'h2000, 32'h0, 32'h0, 5'd11, 32'h8011227F, 32'h2000, 4'h1, 32'h0, 32'h0000007F);
        op("sb",    1, 2'd0, 0, 32'h3000, 32'h1, 32'h123456A5, 5'd12, 32'hFFFFFFFF, 32'h3000, 4'h2, 32'hA5A5A5A5, 32'h0);
        op("sw",    1, 2'd2, 0, 32'h3000, 32'h4, 32'h0BADF00D, 5'd13, 32'hFFFFFFFF, 32'h3004, 4'hF, 32'h0BADF00D, 32'h0);
        op("wrap",  0, 2'd2, 0, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd14, 32'h55AA55AA, 32'h4, 4'hF, 32'h0, 32'h55AA55AA);
        op("negoff",0, 2'd2, 0, 32'h1008, 32'hFFFFFFFC, 32'h0, 5'd15, 32'h01234567, 32'h1004, 4'hF, 32'h0, 32'h01234567);

`ifdef LSU_MISALIGN_TRAP_EN
        issue(0, 2'd2, 0, 32'h2000, 32'h1, 32'h0, 5'd3);
        step();
        req_valid = 1'b0;
        check("lwmis.mis",   32'(misalign), 32'd1);
        check("lwmis.faddr", fault_addr, 32'h2001);
        check("lwmis.req",   32'(dmem_req), 32'd0);
        check("lwmis.stall", 32'(stall), 32'd0);
        step();
        check("lwmis.mis0",  32'(misalign), 32'd0);
        check("lwmis.req0",  32'(dmem_req), 32'd0);
`else
        op("lwmis", 0, 2'd2, 0, 32'h2000, 32'h1, 32'h0, 5'd3, 32'hCAFEF00D, 32'h2000, 4'hF, 32'h0, 32'hCAFEF00D);
`endif

        // Doubleword on a 32-bit core is always rejected.
        issue(0, 2'd3, 0, 32'h3000, 32'h0, 32'h0, 5'd4);
        step();
        req_valid = 1'b0;
        check("ld32.mis",   32'(misalign), 32'd1);
        check("ld32.faddr", fault_addr, 32'h3000);
        check("ld32.req",   32'(dmem_req), 32'd0);
        check("ld32.stall", 32'(stall), 32'd0);
        step();
        check("ld32.mis0",  32'(misalign), 32'd0);
        check("ld32.ready", 32'(req_ready), 32'd1);

        // Grant never arrives: fault in cycle 16 after accept.
        issue(0, 2'd2, 0, 32'h4000, 32'h0, 32'h0, 5'd1);
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            check("to.req",   32'(dmem_req), 32'd1);
            check("to.fault", 32'(fault), 32'd0);
            step();
        end
        check("to.fault16", 32'(fault), 32'd1);
        check("to.faddr",   fault_addr, 32'h4000);
        check("to.reqdrop", 32'(dmem_req), 32'd0);
        check("to.resp",    32'(resp_valid), 32'd0);
        step();
        check("to.ready",   32'(req_ready), 32'd1);
        check("to.fault0",  32'(fault), 32'd0);

        // Response arriving in the timeout cycle wins.
        issue(0, 2'd2, 0, 32'h5000, 32'h0, 32'h0, 5'd9);
        step();
        req_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        for (int k = 2; k <= 14; k++) begin
            check("race.stall", 32'(stall), 32'd1);
            step();
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h13579BDF;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        check("race.resp",  32'(resp_valid), 32'd1);
        check("race.fault", 32'(fault), 32'd0);
        check("race.rdata", rdata, 32'h13579BDF);
        check("race.rd",    32'(rd_out), 32'd9);
        step();

        // Reset while waiting abandons the access; a late response is ignored.
        issue(0, 2'd2, 0, 32'h6000, 32'h0, 32'h0, 5'd2);
        step();
        req_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check("rstw.stall", 32'(stall), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstw.stall0", 32'(stall), 32'd0);
        check("rstw.req",    32'(dmem_req), 32'd0);
        check("rstw.ready",  32'(req_ready), 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0000FFFF;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        check("rstw.resp",   32'(resp_valid), 32'd0);
        step();
        check("rstw.resp2",  32'(resp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
